// File: rtl/vend_pkg.sv
// Shared vending definitions for the coin return path.
//   state_t         : scheduler FSM states
//   coin_job_t      : one requester's {valid, amount} pair
//   COIN_UNIT       : value of one hopper coin in dollars
//   ACK_TIMEOUT_DEF : default cycles to wait for a hopper ack
package vend_pkg;

  localparam int COIN_UNIT       = 10;
  localparam int ACK_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_JAM  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] amount;
  } coin_job_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant.
//   clk, rst_n : clock, async active-low reset (already synchronised)
//   req[1:0]   : bit 0 = change, bit 1 = refund
//   advance    : a grant was consumed this cycle; update the priority
//   gnt[1:0]   : one-hot combinational grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1: refund wins a tie (change was granted last); reset favours change.
  logic prio_rfd;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_rfd ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prio_rfd <= 1'b0;
    else if (advance) prio_rfd <= gnt[0];
  end

endmodule

// File: rtl/coin_return_scheduler.sv
// Coin return scheduler: accepts change/refund jobs from two requesters,
// ejects one $10 coin per hopper handshake, and flags a sticky jam when
// the hopper fails to ack within ACK_TIMEOUT cycles.
//   clk, reset                     : clock, async active-low reset
//   chg_valid/amount/ready         : change request handshake
//   rfd_valid/amount/ready         : refund request handshake
//   coin_req / coin_ack            : hopper eject request / one-cycle ack
//   change_return                  : one-cycle pulse per coin returned
//   pending                        : coins still owed on the current job
//   busy / done / jam              : job active / job-complete pulse / fault
module coin_return_scheduler
  import vend_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chg_valid,
  input  logic [3:0] chg_amount,
  output logic       chg_ready,
  input  logic       rfd_valid,
  input  logic [3:0] rfd_amount,
  output logic       rfd_ready,
  output logic       coin_req,
  input  logic       coin_ack,
  output logic       change_return,
  output logic [3:0] pending,
  output logic       busy,
  output logic       done,
  output logic       jam
);

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  // Assert asynchronously, release two edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic       coin_req_q, coin_req_d;
  logic       ret_q, ret_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       jam_q, jam_d;

  coin_job_t  chg_job, rfd_job;
  logic [1:0] gnt;
  logic       open_q;
  logic       accept;
  logic [3:0] sel_amount;

  assign chg_job = '{valid: chg_valid, amount: chg_amount};
  assign rfd_job = '{valid: rfd_valid, amount: rfd_amount};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({rfd_job.valid, chg_job.valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  // Readies stay low until the synchronised reset has released.
  assign open_q     = rst_n && (state_q == S_IDLE) && !jam_q;
  assign chg_ready  = open_q && gnt[0];
  assign rfd_ready  = open_q && gnt[1];
  assign accept     = chg_ready || rfd_ready;
  assign sel_amount = gnt[1] ? rfd_job.amount : chg_job.amount;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    coin_req_d = 1'b0;
    ret_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    jam_d      = jam_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (sel_amount != 4'd0) begin
            state_d    = S_REQ;
            pend_d     = sel_amount;
            cnt_d      = 8'd0;
            busy_d     = 1'b1;
            coin_req_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        // An ack on the timeout edge still wins over the jam.
        if (coin_ack) begin
          ret_d  = 1'b1;
          pend_d = pend_q - 4'd1;
          if (pend_q == 4'd1) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == WAIT_LAST) begin
            state_d = S_JAM;
            jam_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            coin_req_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        state_d    = S_REQ;
        cnt_d      = 8'd0;
        coin_req_d = 1'b1;
      end
      default: ;  // S_JAM: held until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= 4'd0;
      cnt_q      <= 8'd0;
      coin_req_q <= 1'b0;
      ret_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      jam_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      coin_req_q <= coin_req_d;
      ret_q      <= ret_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      jam_q      <= jam_d;
    end
  end

  assign coin_req      = coin_req_q;
  assign change_return = ret_q;
  assign pending       = pend_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign jam           = jam_q;

endmodule

// File: tb/tb_coin_return_scheduler.sv
module tb_coin_return_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       chg_valid = 1'b0, rfd_valid = 1'b0;
  logic [3:0] chg_amount = 4'd0, rfd_amount = 4'd0;
  logic       chg_ready, rfd_ready, coin_req, coin_ack, change_return;
  logic [3:0] pending;
  logic       busy, done, jam;
  logic       hop_ack = 1'b0, stray_ack = 1'b0;

  assign coin_ack = hop_ack | stray_ack;

  always #5 clk = ~clk;

  coin_return_scheduler #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .chg_valid(chg_valid), .chg_amount(chg_amount), .chg_ready(chg_ready),
    .rfd_valid(rfd_valid), .rfd_amount(rfd_amount), .rfd_ready(rfd_ready),
    .coin_req(coin_req), .coin_ack(coin_ack), .change_return(change_return),
    .pending(pending), .busy(busy), .done(done), .jam(jam)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Hopper knobs
  int hop_delay = 1;
  bit hop_en = 1'b1, gap_ack = 1'b0;
  int hop_cnt = 0;
  bit hop_hold = 1'b0;

  // Transaction-level reference: coins owed, expected pulses, last winner.
  int m_pend = 0;
  bit m_cr = 1'b0, m_done = 1'b0;
  int m_last = 1;  // 1: refund granted last, so change wins a tie
  int n_acc_chg = 0, n_acc_rfd = 0, n_pulse = 0, n_done = 0;
  int order_q[$];

  always @(negedge clk) begin
    bit ack_now, hs;
    int src, amt, exp_src;
    hs = 1'b0; src = 0; amt = 0; exp_src = 0;
    if (!reset) begin
      m_pend = 0; m_cr = 1'b0; m_done = 1'b0; m_last = 1;
      hop_cnt = 0; hop_ack = 1'b0; hop_hold = 1'b0;
    end else begin
      if (change_return) n_pulse++;
      if (done) n_done++;
      chk("pending", int'(pending), m_pend);
      chk("change_return", int'(change_return), int'(m_cr));
      chk("done", int'(done), int'(m_done));
      chk("one_ready", int'(chg_ready & rfd_ready), 0);
      if (busy || jam) chk("ready_while_busy", int'(chg_ready | rfd_ready), 0);
      // hopper: ack hop_delay cycles into coin_req, optionally held one extra cycle
      if (hop_en && coin_req) begin
        hop_ack  = (hop_cnt == hop_delay);
        hop_hold = hop_ack && gap_ack;
        hop_cnt++;
      end else begin
        hop_ack  = hop_hold;
        hop_hold = 1'b0;
        hop_cnt  = 0;
      end
      ack_now = hop_ack | stray_ack;
      if (chg_ready && chg_valid) begin
        hs = 1'b1; src = 0; amt = int'(chg_amount); n_acc_chg++;
      end else if (rfd_ready && rfd_valid) begin
        hs = 1'b1; src = 1; amt = int'(rfd_amount); n_acc_rfd++;
      end
      if (hs) begin
        if (chg_valid && rfd_valid) exp_src = (m_last == 0) ? 1 : 0;
        else                        exp_src = chg_valid ? 0 : 1;
        chk("grant", src, exp_src);
        order_q.push_back(src);
        m_last = src;
      end
      m_cr   = coin_req && ack_now;
      m_done = 1'b0;
      if (hs) begin
        if (amt == 0) m_done = 1'b1;
        else          m_pend = amt;
      end else if (m_cr) begin
        m_pend--;
        if (m_pend == 0) m_done = 1'b1;
      end
    end
  end

  typedef struct {
    bit cv; int ca; bit rv; int ra; int delay; bit gap;
    int pulses; int dones; int first;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int p0, d0, c0, r0, q0, cyc;
    bit ok;
    p0 = n_pulse; d0 = n_done; c0 = n_acc_chg; r0 = n_acc_rfd;
    q0 = order_q.size(); cyc = 0; ok = 1'b0;
    hop_delay = v.delay; gap_ack = v.gap;
    chg_amount = 4'(v.ca); rfd_amount = 4'(v.ra);
    chg_valid = v.cv; rfd_valid = v.rv;
    while (cyc < 600) begin
      @(posedge clk); #1; cyc++;
      if (n_acc_chg != c0) chg_valid = 1'b0;
      if (n_acc_rfd != r0) rfd_valid = 1'b0;
      if (!chg_valid && !rfd_valid && !busy) begin ok = 1'b1; break; end
    end
    chg_valid = 1'b0; rfd_valid = 1'b0;
    chk({nm, "_finish"}, int'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_pulses"}, n_pulse - p0, v.pulses);
    chk({nm, "_dones"}, n_done - d0, v.dones);
    if (v.cv && v.rv) chk({nm, "_first"}, (order_q.size() > q0) ? order_q[q0] : -1, v.first);
  endtask

  vec_t tbl[13];
  vec_t post;

  initial begin
    int c0, r0, p0, d0, cyc, creq;
    bit seen;
    //            cv ca  rv ra dly gap pls dns first
    tbl[0]  = '{1, 1,  1, 2, 1,  0,  3,  2,  0};
    tbl[1]  = '{1, 3,  0, 0, 1,  0,  3,  1,  0};
    tbl[2]  = '{0, 0,  1, 0, 1,  0,  0,  1,  1};
    tbl[3]  = '{1, 2,  1, 1, 0,  0,  3,  2,  0};
    tbl[4]  = '{0, 0,  1, 3, 2,  1,  3,  1,  1};
    tbl[5]  = '{1, 0,  1, 0, 1,  0,  0,  2,  0};
    tbl[6]  = '{0, 0,  1, 1, 3,  0,  1,  1,  1};
    tbl[7]  = '{1, 1,  1, 1, 0,  1,  2,  2,  0};
    tbl[8]  = '{1, 2,  0, 0, 1,  0,  2,  1,  0};
    tbl[9]  = '{1, 1,  1, 3, 2,  0,  4,  2,  1};
    tbl[10] = '{1, 15, 0, 0, 0,  0, 15,  1,  0};
    tbl[11] = '{1, 1,  0, 0, 15, 0,  1,  1,  0};
    tbl[12] = '{0, 0,  1, 2, 14, 1,  2,  1,  1};
    post    = '{1, 1,  1, 1, 1,  0,  2,  2,  0};

    // Reset state, with a change request already waiting.
    chg_valid = 1'b1; chg_amount = 4'd3;
    #2 reset = 1'b0;
    #1;
    chk("rst_coin_req", int'(coin_req), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_jam", int'(jam), 0);
    chk("rst_change_return", int'(change_return), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chg_ready", int'(chg_ready), 0);
    chg_valid = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Randomised jobs, hopper delays below the timeout.
    for (int i = 0; i < 12; i++) begin
      vec_t rv;
      rv.cv = 1'($urandom_range(0, 1));
      rv.rv = rv.cv ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.ca = rv.cv ? int'($urandom_range(0, 6)) : 0;
      rv.ra = rv.rv ? int'($urandom_range(0, 6)) : 0;
      rv.delay = int'($urandom_range(0, 6));
      rv.gap = 1'($urandom_range(0, 1));
      rv.pulses = rv.ca + rv.ra;
      rv.dones = int'(rv.cv) + int'(rv.rv);
      rv.first = (m_last == 0) ? 1 : 0;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Stray ack while idle.
    p0 = n_pulse;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ack_pulses", n_pulse - p0, 0);
    chk("idle_ack_pending", int'(pending), 0);

    // Silent hopper -> jam after 16 cycles of coin_req.
    hop_en = 1'b0;
    c0 = n_acc_chg; creq = 0; seen = 1'b0;
    chg_amount = 4'd2; chg_valid = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (n_acc_chg != c0) chg_valid = 1'b0;
      if (coin_req) creq++;
      if (jam) begin seen = 1'b1; break; end
    end
    chg_valid = 1'b0;
    chk("jam_seen", int'(seen), 1);
    chk("jam_req_cycles", creq, 16);
    chk("jam_coin_req", int'(coin_req), 0);
    chk("jam_pending", int'(pending), 2);
    chk("jam_busy", int'(busy), 0);
    r0 = n_acc_rfd;
    rfd_amount = 4'd1; rfd_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("jam_rfd_ready", int'(rfd_ready), 0);
    chk("jam_no_accept", n_acc_rfd - r0, 0);
    chk("jam_sticky", int'(jam), 1);
    rfd_valid = 1'b0;

    #2 reset = 1'b0;
    #1;
    chk("jam_rst_jam", int'(jam), 0);
    chk("jam_rst_pending", int'(pending), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    hop_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a 5-coin job once pending reaches 3.
    hop_delay = 2; gap_ack = 1'b0;
    c0 = n_acc_chg; seen = 1'b0;
    chg_amount = 4'd5; chg_valid = 1'b1;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      if (n_acc_chg != c0) chg_valid = 1'b0;
      if (pending == 4'd3) begin seen = 1'b1; break; end
    end
    chg_valid = 1'b0;
    chk("mid_pending3", int'(seen), 1);
    d0 = n_done;
    #2 reset = 1'b0;
    #1;
    chk("mid_coin_req", int'(coin_req), 0);
    chk("mid_change_return", int'(change_return), 0);
    chk("mid_pending", int'(pending), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_jam", int'(jam), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_done", n_done - d0, 0);
    run_vec(post, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
